board_input_conditioner: RTL and testbench

- Parametrised N-channel conditioner for asynchronous board inputs: buttons, PS/2 lines sampled as inputs, and the inter-board UART rx line.
- Sits between the board top and the game core, replacing raw pin-to-core wiring.
- Per channel: multi-stage synchroniser, optional debounce filter (per-channel bypass mode), and registered level plus rise/fall strobes in the core clock domain.

---
 rtl/snake_pkg.sv | 8 +
 rtl/input_conditioner_ch.sv | 69 ++++++
 rtl/board_input_conditioner.sv | 49 ++++
 tb/tb_board_input_conditioner.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake game board: core clock rate and the
// standard debounce interval expressed in core clock cycles.
package snake_pkg;

  localparam int unsigned CLK_CORE_HZ   = 75_000_000;
  localparam int unsigned DEBOUNCE_10MS = CLK_CORE_HZ / 100;

endpackage

// File: rtl/input_conditioner_ch.sv
// One input channel: N-flop synchroniser, optional consecutive-stable-cycles
// debounce filter, registered level and single-cycle rise/fall strobes.
module input_conditioner_ch
  import snake_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter bit          IDLE            = 1'b0,
  parameter bit          BYPASS          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_change_d
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;
  logic                   w_flip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= {SYNC_STAGES{IDLE}};
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // A one-cycle filter is the same as no filter, so it shares the counter-free path.
  if (BYPASS || DEBOUNCE_CYCLES == 1) begin : g_byp
    assign w_flip = (w_s != r_level);
  end else begin : g_deb
    localparam int unsigned   CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                r_cnt <= '0;
      else if (w_s == r_level || r_cnt == LAST) r_cnt <= '0;
      else                                    r_cnt <= r_cnt + CW'(1);
    end

    assign w_flip = (w_s != r_level) && (r_cnt == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= IDLE;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      if (w_flip) r_level <= w_s;
      r_rise <= w_flip & w_s;
      r_fall <= w_flip & ~w_s;
    end
  end

  assign o_level    = r_level;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_change_d = w_flip;

endmodule

// File: rtl/board_input_conditioner.sv
// N-channel conditioner between raw board pins and the game core; each
// channel is synchronised, optionally debounced, and edge-detected.
module board_input_conditioner
  import snake_pkg::*;
#(
  parameter int unsigned       N_CH            = 4,
  parameter int unsigned       SYNC_STAGES     = 2,
  parameter int unsigned       DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter logic [N_CH-1:0]   IDLE_LEVEL      = '0,
  parameter logic [N_CH-1:0]   BYPASS_MASK     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in_raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_change
);

  logic [N_CH-1:0] w_change;
  logic            r_any;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    input_conditioner_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE           (IDLE_LEVEL[i]),
      .BYPASS         (BYPASS_MASK[i])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_raw     (in_raw[i]),
      .o_level   (level[i]),
      .o_rise    (rise[i]),
      .o_fall    (fall[i]),
      .o_change_d(w_change[i])
    );
  end

  // Registered from the channels' next-cycle strobes so it aligns with rise/fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_any <= 1'b0;
    else     r_any <= |w_change;
  end

  assign any_change = r_any;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench: ch0 bypass with idle-high, ch1..3 debounced over 8 cycles.
module tb_board_input_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] in_raw;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any_change;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [3:0] seen_r;
  logic [3:0] seen_f;
  logic       seen_a;

  board_input_conditioner #(
    .N_CH           (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .IDLE_LEVEL     (4'b0001),
    .BYPASS_MASK    (4'b0001)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_raw    (in_raw),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .any_change(any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic clr_seen();
    seen_r = '0;
    seen_f = '0;
    seen_a = 1'b0;
  endtask

  // Advance n falling edges, accumulating any strobe activity seen.
  task automatic cyc(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      seen_r |= rise;
      seen_f |= fall;
      seen_a |= any_change;
    end
  endtask

  initial begin
    rst    = 1'b0;
    in_raw = 4'b1110;
    clr_seen();
    #2 rst = 1'b1;

    // reset values with inputs opposite to idle
    cyc(3);
    chk("rst_level", level, 4'b0001);
    chk("rst_rise_seen", seen_r, 4'b0000);
    chk("rst_fall_seen", seen_f, 4'b0000);
    chk("rst_any_seen", {3'b000, seen_a}, 4'b0000);

    in_raw = 4'b0001;
    cyc(1);
    rst = 1'b0;
    clr_seen();
    cyc(4);
    chk("release_level", level, 4'b0001);
    chk("release_quiet", seen_r | seen_f, 4'b0000);

    // bypass channel latency: 3 edges
    in_raw = 4'b0000;
    cyc(2);
    chk("byp_level_edge2", level, 4'b0001);
    chk("byp_fall_edge2", fall, 4'b0000);
    cyc(1);
    chk("byp_level_edge3", level, 4'b0000);
    chk("byp_fall_edge3", fall, 4'b0001);
    chk("byp_any_edge3", {3'b000, any_change}, 4'b0001);
    chk("byp_rise_edge3", rise, 4'b0000);
    cyc(1);
    chk("byp_fall_edge4", fall, 4'b0000);
    chk("byp_any_edge4", {3'b000, any_change}, 4'b0000);

    // bounce rejection on ch1: longest run is 7 < 8
    clr_seen();
    in_raw[1] = 1'b1; cyc(3);
    in_raw[1] = 1'b0; cyc(2);
    in_raw[1] = 1'b1; cyc(7);
    in_raw[1] = 1'b0; cyc(12);
    chk("bounce_level", level, 4'b0000);
    chk("bounce_rise_seen", seen_r, 4'b0000);
    chk("bounce_fall_seen", seen_f, 4'b0000);
    chk("bounce_any_seen", {3'b000, seen_a}, 4'b0000);

    // debounce accept: flip on edge SYNC_STAGES+8 = 10
    in_raw[1] = 1'b1;
    cyc(9);
    chk("deb_rise_level_e9", level, 4'b0000);
    chk("deb_rise_e9", rise, 4'b0000);
    cyc(1);
    chk("deb_rise_level_e10", level, 4'b0010);
    chk("deb_rise_e10", rise, 4'b0010);
    chk("deb_rise_any_e10", {3'b000, any_change}, 4'b0001);
    cyc(1);
    chk("deb_rise_e11", rise, 4'b0000);
    chk("deb_rise_any_e11", {3'b000, any_change}, 4'b0000);
    in_raw[1] = 1'b0;
    cyc(9);
    chk("deb_fall_level_e9", level, 4'b0010);
    cyc(1);
    chk("deb_fall_e10", fall, 4'b0010);
    chk("deb_fall_level_e10", level, 4'b0000);
    cyc(1);
    chk("deb_fall_e11", fall, 4'b0000);

    // simultaneous channels share one any_change pulse
    in_raw = 4'b1100;
    cyc(9);
    chk("sim_rise_e9", rise, 4'b0000);
    chk("sim_any_e9", {3'b000, any_change}, 4'b0000);
    cyc(1);
    chk("sim_rise_e10", rise, 4'b1100);
    chk("sim_any_e10", {3'b000, any_change}, 4'b0001);
    cyc(1);
    chk("sim_rise_e11", rise, 4'b0000);
    chk("sim_any_e11", {3'b000, any_change}, 4'b0000);
    in_raw = 4'b0000;
    cyc(10);
    chk("sim_fall_e10", fall, 4'b1100);
    chk("sim_fall_level", level, 4'b0000);
    cyc(2);

    // reset mid-count on ch1
    in_raw = 4'b0010;
    cyc(5);
    chk("mid_cnt_before", dut.g_ch[1].u_ch.g_deb.r_cnt, 4'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_level", level, 4'b0001);
    chk("mid_rst_cnt", dut.g_ch[1].u_ch.g_deb.r_cnt, 4'd0);
    chk("mid_rst_strobes", rise | fall, 4'b0000);
    clr_seen();
    cyc(2);
    chk("mid_rst_hold_quiet", seen_r | seen_f, 4'b0000);
    rst = 1'b0;
    cyc(3);
    chk("mid_rel_ch0_fall", fall, 4'b0001);
    chk("mid_rel_ch0_level", level, 4'b0000);
    cyc(6);
    chk("mid_rel_level_e9", level, 4'b0000);
    chk("mid_rel_rise_e9", rise, 4'b0000);
    cyc(1);
    chk("mid_rel_rise_e10", rise, 4'b0010);
    chk("mid_rel_fall_e10", fall, 4'b0000);
    chk("mid_rel_level_e10", level, 4'b0010);
    chk("mid_rel_any_e10", {3'b000, any_change}, 4'b0001);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
